// File: rtl/tile_pkg.sv
// Shared constants and types for the tile pixel serializer and its delay line.
package tile_pkg;

    localparam int unsigned PIX_W    = 4;
    localparam int unsigned TILE_PIX = 8;
    localparam int unsigned ROM_W    = 32;
    localparam int unsigned WORD_W   = 8;
    localparam int unsigned COL_W    = 4;
    localparam int unsigned FINE_W   = 3;
    localparam int unsigned DL_DEPTH = 8;

    typedef logic [WORD_W-1:0] pix_word_t;

endpackage

// File: rtl/pixel_delay_line.sv
// Enable-gated word delay line with a tap mux: sel 0 passes the input through,
// sel n returns the word delayed by n enabled edges.
module pixel_delay_line #(
    parameter int unsigned Depth = 8,
    parameter int unsigned Width = 8,
    localparam int unsigned SelW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    input  logic [SelW-1:0]  sel_i,
    output logic [Width-1:0] tap_o
);

    logic [Width-1:0] dl_q [Depth];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                dl_q[i] <= '0;
            end
        end else if (en_i) begin
            dl_q[0] <= d_i;
            for (int i = 1; i < Depth; i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    assign tap_o = (sel_i == '0) ? d_i : dl_q[sel_i - 1'b1];

endmodule

// File: rtl/tile_pixel_serializer.sv
// Serialises one tile ROM row per 8 pixel clocks into colour-tagged pixel words,
// with optional horizontal flip and 0-7 pixels of fine-scroll delay.
module tile_pixel_serializer
    import tile_pkg::ROM_W, tile_pkg::WORD_W, tile_pkg::COL_W, tile_pkg::FINE_W,
           tile_pkg::DL_DEPTH, tile_pkg::pix_word_t;
#(
    parameter int unsigned PIX_W    = tile_pkg::PIX_W,
    parameter int unsigned TILE_PIX = tile_pkg::TILE_PIX
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              PXL_EN,
    input  logic              HRST,
    input  logic [ROM_W-1:0]  ROM_D,
    input  logic [COL_W-1:0]  COL,
    input  logic              FLIPX,
    input  logic [FINE_W-1:0] FINE,
    output logic [WORD_W-1:0] PIX,
    output logic              OPAQUE,
    output logic              PIX_VLD
);

    localparam int unsigned CntW = $clog2(TILE_PIX);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ROM_W-1:0]  sr_q, sr_d, rom_flip;
    logic [COL_W-1:0]  colr_q, colr_d;
    logic [FINE_W-1:0] fine_l_q, fine_l_d;
    logic [FINE_W-1:0] fill_q, fill_d;
    logic              started_q, started_d;
    logic              vld_q, vld_d;
    pix_word_t         pix_q, pix_d, word, tap;

    always_comb begin
        rom_flip = '0;
        for (int i = 0; i < TILE_PIX; i++) begin
            rom_flip[i*PIX_W +: PIX_W] = ROM_D[(TILE_PIX-1-i)*PIX_W +: PIX_W];
        end
    end

    assign word = {colr_q, sr_q[ROM_W-1 -: PIX_W]};

    pixel_delay_line #(
        .Depth (DL_DEPTH),
        .Width (WORD_W)
    ) u_delay (
        .clk_i (CK),
        .rst_i (RST),
        .en_i  (PXL_EN),
        .d_i   (word),
        .sel_i (fine_l_q),
        .tap_o (tap)
    );

    always_comb begin
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        colr_d    = colr_q;
        fine_l_d  = fine_l_q;
        fill_d    = fill_q;
        started_d = started_q;
        vld_d     = vld_q;
        pix_d     = pix_q;
        if (PXL_EN) begin
            pix_d = tap;
            cnt_d = cnt_q + 1'b1;
            sr_d  = {sr_q[ROM_W-PIX_W-1:0], {PIX_W{1'b0}}};
            if (HRST) begin
                cnt_d     = '0;
                fine_l_d  = FINE;
                fill_d    = '0;
                started_d = 1'b0;
                vld_d     = 1'b0;
            end else begin
                if (cnt_q == CntW'(TILE_PIX - 1)) begin
                    sr_d      = FLIPX ? rom_flip : ROM_D;
                    colr_d    = COL;
                    started_d = 1'b1;
                end
                // Pixel 0 of the first load reaches PIX fine_l edges after the edge following it.
                if (started_q && !vld_q) begin
                    if (fill_q == fine_l_q) begin
                        vld_d = 1'b1;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            cnt_q     <= '0;
            sr_q      <= '0;
            colr_q    <= '0;
            fine_l_q  <= '0;
            fill_q    <= '0;
            started_q <= 1'b0;
            vld_q     <= 1'b0;
            pix_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            colr_q    <= colr_d;
            fine_l_q  <= fine_l_d;
            fill_q    <= fill_d;
            started_q <= started_d;
            vld_q     <= vld_d;
            pix_q     <= pix_d;
        end
    end

    assign PIX     = pix_q;
    assign PIX_VLD = vld_q;
    assign OPAQUE  = |pix_q[PIX_W-1:0];

endmodule

// File: tb/tb_tile_pixel_serializer.sv
// Scoreboard bench: stimulus queues expected pixel words tagged with the enabled-edge
// index (relative to HRST/RST) at which each must appear; a monitor pops and compares.
module tb_tile_pixel_serializer;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        PXL_EN = 1'b0;
    logic        HRST = 1'b0;
    logic [31:0] ROM_D = '0;
    logic [3:0]  COL = '0;
    logic        FLIPX = 1'b0;
    logic [2:0]  FINE = '0;
    logic [7:0]  PIX;
    logic        OPAQUE;
    logic        PIX_VLD;

    typedef struct {
        int         idx;
        logic [7:0] pix;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    tile_pixel_serializer #(
        .PIX_W    (4),
        .TILE_PIX (8)
    ) dut (
        .CK      (CK),
        .RST     (RST),
        .PXL_EN  (PXL_EN),
        .HRST    (HRST),
        .ROM_D   (ROM_D),
        .COL     (COL),
        .FLIPX   (FLIPX),
        .FINE    (FINE),
        .PIX     (PIX),
        .OPAQUE  (OPAQUE),
        .PIX_VLD (PIX_VLD)
    );

    initial forever #5 CK = ~CK;

    // Monitor: index enabled edges, pop on every valid enabled edge, check hold otherwise.
    initial begin
        logic       en_s, hr_s, rs_s;
        int         idx;
        logic [7:0] last_pix;
        exp_t       e;
        idx      = 0;
        last_pix = '0;
        forever begin
            @(posedge CK);
            en_s = PXL_EN;
            hr_s = HRST;
            rs_s = RST;
            #1;
            if (rs_s) begin
                idx = 0;
            end else if (en_s) begin
                if (hr_s) idx = 0;
                else idx++;
                if (PIX_VLD) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_pix: edge %0d got PIX=%02h, none expected",
                                 idx, PIX);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.idx != idx || PIX !== e.pix || OPAQUE !== (e.pix[3:0] != 4'h0))
                        begin
                            n_err++;
                            $display("FAIL pix_seq: got edge %0d PIX=%02h OPAQUE=%b, want edge %0d PIX=%02h OPAQUE=%b",
                                     idx, PIX, OPAQUE, e.idx, e.pix, e.pix[3:0] != 4'h0);
                        end
                    end
                    last_pix = PIX;
                end
            end else if (PIX_VLD) begin
                n_vec++;
                if (PIX !== last_pix) begin
                    n_err++;
                    $display("FAIL hold: got PIX=%02h, want %02h", PIX, last_pix);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic push_line(input logic [31:0] rom, input logic [3:0] col, input logic flip,
                             input int base);
        logic [3:0] nib;
        for (int k = 0; k < 8; k++) begin
            nib = flip ? rom[4*k +: 4] : rom[28-4*k +: 4];
            exp_q.push_back('{idx: base + k, pix: {col, nib}});
        end
    endtask

    // Called at a negedge: one enabled HRST edge that ends the current line.
    task automatic close_line();
        PXL_EN = 1'b1;
        HRST   = 1'b1;
        @(negedge CK);
        PXL_EN = 1'b0;
        HRST   = 1'b0;
        chk("vld_cleared_by_hrst", int'(PIX_VLD), 0);
    endtask

    task automatic run_line(input logic [31:0] rom, input logic [3:0] col, input logic flip,
                            input logic [2:0] fine, input int period, input int chg_at,
                            input logic [2:0] fine_new, input int glitch_at);
        push_line(rom, col, flip, 9 + int'(fine));
        @(negedge CK);
        ROM_D  = rom;
        COL    = col;
        FLIPX  = flip;
        FINE   = fine;
        PXL_EN = 1'b1;
        HRST   = 1'b1;
        @(negedge CK);
        HRST = 1'b0;
        for (int e = 1; e <= 16 + int'(fine); e++) begin
            PXL_EN = 1'b0;
            for (int d = 1; d < period; d++) begin
                if (e == glitch_at && d == 1) HRST = 1'b1;
                @(negedge CK);
                HRST = 1'b0;
            end
            PXL_EN = 1'b1;
            if (e == chg_at) FINE = fine_new;
            @(negedge CK);
        end
        PXL_EN = 1'b0;
        @(negedge CK);
        chk("queue_drained", exp_q.size(), 0);
        close_line();
    endtask

    initial begin
        RST    = 1'b1;
        PXL_EN = 1'b0;
        repeat (2) @(negedge CK);
        chk("rst_pix", int'(PIX), 0);
        chk("rst_vld", int'(PIX_VLD), 0);
        chk("rst_opaque", int'(OPAQUE), 0);
        RST = 1'b0;

        // Straight, flipped, fine scroll with mid-line FINE change, sparse enable.
        run_line(32'h12345678, 4'hA, 1'b0, 3'd0, 1, 0, 3'd0, 0);
        run_line(32'h12345678, 4'hA, 1'b1, 3'd0, 1, 0, 3'd0, 0);
        run_line(32'h12345678, 4'hA, 1'b0, 3'd3, 1, 6, 3'd5, 0);
        run_line(32'h12345678, 4'hA, 1'b0, 3'd0, 4, 0, 3'd0, 5);
        run_line(32'h01000000, 4'h3, 1'b0, 3'd0, 1, 0, 3'd0, 0);
        run_line(32'hFEDCBA98, 4'h6, 1'b1, 3'd7, 1, 0, 3'd0, 0);

        // Reset mid-tile: HRST with FINE=2, RST on the edge that sees CNT=4.
        @(negedge CK);
        ROM_D  = 32'h9ABCDEF0;
        COL    = 4'h5;
        FLIPX  = 1'b0;
        FINE   = 3'd2;
        PXL_EN = 1'b1;
        HRST   = 1'b1;
        @(negedge CK);
        HRST = 1'b0;
        repeat (4) @(negedge CK);
        push_line(32'h9ABCDEF0, 4'h5, 1'b0, 9);
        RST = 1'b1;
        @(negedge CK);
        RST = 1'b0;
        chk("midtile_rst_pix", int'(PIX), 0);
        chk("midtile_rst_vld", int'(PIX_VLD), 0);
        chk("midtile_rst_opaque", int'(OPAQUE), 0);
        repeat (16) @(negedge CK);
        PXL_EN = 1'b0;
        @(negedge CK);
        chk("queue_drained_rst", exp_q.size(), 0);
        close_line();

        repeat (3) @(negedge CK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
